// File: rtl/lbp_hist_pkg.sv
// Shared constants, state encoding and border-check helper for the LBP histogram block.
package lbp_hist_pkg;

    localparam int unsigned IMG_W   = 128;
    localparam int unsigned NBINS   = 256;
    localparam int unsigned CNT_W   = 14;
    localparam int unsigned COORD_W = 7;
    localparam int unsigned ADDR_W  = 2 * COORD_W;
    localparam int unsigned BIN_W   = 8;

    // Border rows/cols sit at the first and last coordinate of the image.
    localparam logic [COORD_W-1:0] EDGE_LO = '0;
    localparam logic [COORD_W-1:0] EDGE_HI = COORD_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        StAcc   = 2'd0,
        StDrain = 2'd1,
        StOut   = 2'd2,
        StDone  = 2'd3
    } state_e;

    function automatic logic is_border(input logic [COORD_W-1:0] row,
                                       input logic [COORD_W-1:0] col,
                                       input logic [COORD_W-1:0] edge_hi);
        return (row == EDGE_LO) || (row == edge_hi) || (col == EDGE_LO) || (col == edge_hi);
    endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// Array of saturating bin counters: one increment port, one combinational read port,
// asynchronous clear.
module lbp_hist_bank #(
    parameter int unsigned NBINS = 256,
    parameter int unsigned CNT_W = 14,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [AW-1:0]    inc_addr,
    input  logic [AW-1:0]    rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] bins_q [NBINS];
    logic             inc_sat;

    assign inc_sat = (bins_q[inc_addr] == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NBINS); i++) begin
                bins_q[i] <= '0;
            end
        end else if (inc_en && !inc_sat) begin
            bins_q[inc_addr] <= bins_q[inc_addr] + 1'b1;
        end
    end

    assign rd_data = bins_q[rd_addr];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates interior samples into NBINS counters, then streams
// the bins out over a valid/ready handshake.
module lbp_hist #(
    parameter int unsigned IMG_W = lbp_hist_pkg::IMG_W,
    parameter int unsigned NBINS = lbp_hist_pkg::NBINS,
    parameter int unsigned CNT_W = lbp_hist_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic [CNT_W-1:0] total_count,
    output logic             addr_err,
    output logic             done
);

    import lbp_hist_pkg::*;

    localparam logic [COORD_W-1:0] EdgeHi  = COORD_W'(IMG_W - 1);
    localparam logic [BIN_W-1:0]   LastBin = BIN_W'(NBINS - 1);

    state_e             state_q, state_d;
    logic               in_valid_q;
    logic [BIN_W-1:0]   in_bin_q;
    logic [CNT_W-1:0]   total_q;
    logic               addr_err_q;
    logic [BIN_W-1:0]   hist_bin_q, hist_bin_d;
    logic               hist_valid_q;
    logic               done_q;

    logic [COORD_W-1:0] row, col;
    logic               border;
    logic               in_acc;
    logic               take;
    logic               xfer;
    logic               total_sat;

    assign row       = lbp_addr[13:7];
    assign col       = lbp_addr[6:0];
    assign border    = is_border(row, col, EdgeHi);
    assign in_acc    = (state_q == StAcc);
    assign take      = in_acc && lbp_valid && !border;
    assign xfer      = hist_valid_q && hist_ready;
    assign total_sat = (total_q == {CNT_W{1'b1}});

    always_comb begin
        state_d    = state_q;
        hist_bin_d = hist_bin_q;
        case (state_q)
            StAcc: begin
                if (finish) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The input stage commits its last sample during this cycle.
                state_d    = StOut;
                hist_bin_d = '0;
            end
            StOut: begin
                if (xfer) begin
                    if (hist_bin_q == LastBin) begin
                        state_d = StDone;
                    end else begin
                        hist_bin_d = hist_bin_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StAcc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StAcc;
            in_valid_q   <= 1'b0;
            in_bin_q     <= '0;
            total_q      <= '0;
            addr_err_q   <= 1'b0;
            hist_bin_q   <= '0;
            hist_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_valid_q <= take;
            if (take) begin
                in_bin_q <= lbp_data;
            end
            if (in_valid_q && !total_sat) begin
                total_q <= total_q + 1'b1;
            end
            if (in_acc && lbp_valid && border) begin
                addr_err_q <= 1'b1;
            end
            hist_bin_q   <= hist_bin_d;
            hist_valid_q <= (state_d == StOut);
            done_q       <= (state_d == StDone);
        end
    end

    lbp_hist_bank #(
        .NBINS (NBINS),
        .CNT_W (CNT_W),
        .AW    (BIN_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (in_valid_q),
        .inc_addr (in_bin_q),
        .rd_addr  (hist_bin_q),
        .rd_data  (hist_count)
    );

    assign hist_valid  = hist_valid_q;
    assign hist_bin    = hist_bin_q;
    assign total_count = total_q;
    assign addr_err    = addr_err_q;
    assign done        = done_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist: vector table, directed corner sequences and a
// randomized run against a bin-array reference model.
module tb_lbp_hist;

    localparam int NB   = 256;
    localparam int MAXC = 16383;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_valid;
    logic        hist_ready;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic [13:0] total_count;
    logic        addr_err;
    logic        done;

    int checks = 0;
    int errors = 0;
    int model_bins [NB];
    int model_total;
    int model_err;

    always #5 clk = ~clk;

    lbp_hist dut (
        .clk         (clk),
        .reset       (reset),
        .lbp_valid   (lbp_valid),
        .lbp_addr    (lbp_addr),
        .lbp_data    (lbp_data),
        .finish      (finish),
        .hist_valid  (hist_valid),
        .hist_ready  (hist_ready),
        .hist_bin    (hist_bin),
        .hist_count  (hist_count),
        .total_count (total_count),
        .addr_err    (addr_err),
        .done        (done)
    );

    typedef struct {
        int addr;
        int data;
        int exp_total;
        int exp_err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int interior(input int addr);
        int row = addr / 128;
        int col = addr % 128;
        return (row >= 1 && row <= 126 && col >= 1 && col <= 126) ? 1 : 0;
    endfunction

    function automatic int rand_interior();
        return int'($urandom_range(1, 126)) * 128 + int'($urandom_range(1, 126));
    endfunction

    task automatic model_add(input int addr, input int data);
        if (interior(addr) != 0) begin
            if (model_bins[data] < MAXC) model_bins[data]++;
            if (model_total < MAXC) model_total++;
        end else begin
            model_err = 1;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) model_bins[i] = 0;
        model_total = 0;
        model_err   = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send(input int addr, input int data);
        lbp_valid = 1'b1;
        lbp_addr  = 14'(addr);
        lbp_data  = 8'(data);
        model_add(addr, data);
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_total"}, int'(total_count), model_total);
        chk({tag, "_addr_err"}, int'(addr_err), model_err);
    endtask

    // entry: 0 = raise finish alone, 1 = finish together with a fresh sample,
    // 2 = finish already seen by the DUT. ready_mode 1 opens with 1,0,0,1 then random.
    task automatic drain(input int entry, input int ready_mode, input int stop_at);
        int a;
        int d;
        int cyc;
        int k;
        int exp_bin;
        int rdy;
        if (entry != 2) begin
            finish    = 1'b1;
            lbp_valid = (entry == 1);
            if (entry == 1) begin
                a = rand_interior();
                d = int'($urandom_range(0, 255));
                lbp_addr = 14'(a);
                lbp_data = 8'(d);
                model_add(a, d);
            end
            @(posedge clk);
            #1;
        end
        // Junk samples from here on must be ignored.
        lbp_valid = 1'b1;
        lbp_addr  = 14'(rand_interior());
        lbp_data  = 8'($urandom_range(0, 255));
        cyc = 0;
        while (!hist_valid && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("out_entry_valid", int'(hist_valid), 1);
        exp_bin = 0;
        k       = 0;
        cyc     = 0;
        while (exp_bin < NB && cyc < 4000) begin
            if (exp_bin == stop_at) begin
                lbp_valid = 1'b0;
                return;
            end
            chk("hist_valid", int'(hist_valid), 1);
            chk("hist_bin", int'(hist_bin), exp_bin);
            chk("hist_count", int'(hist_count), model_bins[exp_bin]);
            if (ready_mode == 0) rdy = 1;
            else if (k < 4) rdy = (k == 1 || k == 2) ? 0 : 1;
            else rdy = int'($urandom_range(0, 1));
            k++;
            hist_ready = rdy[0];
            lbp_valid  = $urandom_range(0, 1) != 0;
            lbp_addr   = 14'(rand_interior());
            lbp_data   = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            cyc++;
            if (rdy != 0) exp_bin++;
        end
        chk("drain_bins_sent", exp_bin, NB);
        chk("done_after_last", int'(done), 1);
        chk("valid_after_last", int'(hist_valid), 0);
        chk("total_after_drain", int'(total_count), model_total);
        hist_ready = 1'b0;
        finish     = 1'b0;
        lbp_valid  = 1'b1;
        idle(3);
        lbp_valid = 1'b0;
        chk("done_held", int'(done), 1);
        chk("valid_held_low", int'(hist_valid), 0);
        chk("total_held", int'(total_count), model_total);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs [7];
        int a;
        int d;
        int prev;

        vecs[0] = '{0,     1, 0, 1};
        vecs[1] = '{127,   2, 0, 1};
        vecs[2] = '{128,   3, 0, 1};
        vecs[3] = '{16383, 4, 0, 1};
        vecs[4] = '{129,   5, 1, 1};
        vecs[5] = '{129,   5, 2, 1};
        vecs[6] = '{129,   5, 3, 1};

        // Reset values
        do_reset();
        chk("rst_valid", int'(hist_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_total", int'(total_count), 0);
        chk("rst_addr_err", int'(addr_err), 0);
        chk("rst_bin", int'(hist_bin), 0);
        chk("rst_count", int'(hist_count), 0);

        // Border samples then three samples of bin 5 at address 129
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].addr, vecs[i].data);
            idle(1);
            chk($sformatf("vec%0d_total", i), int'(total_count), vecs[i].exp_total);
            chk($sformatf("vec%0d_addr_err", i), int'(addr_err), vecs[i].exp_err);
        end
        drain(0, 0, NB);
        chk("three_total", int'(total_count), 3);

        // Full interior, every sample bin 255, last one coincides with finish
        do_reset();
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                lbp_valid = 1'b1;
                lbp_addr  = 14'(r * 128 + c);
                lbp_data  = 8'hFF;
                model_add(r * 128 + c, 255);
                if (r == 126 && c == 126) finish = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        drain(2, 0, NB);
        chk("full_total", int'(total_count), 15876);
        chk("full_addr_err", int'(addr_err), 0);

        // Corner addresses, back-to-back same bin, random traffic, stalled output
        do_reset();
        send(254, 10);
        send(16254, 10);
        send(16129, 11);
        send(16257, 12);
        send(1, 13);
        idle(2);
        check_state("corner");
        prev = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                a = int'($urandom_range(0, 16383));
                d = ($urandom_range(0, 2) == 0) ? prev : int'($urandom_range(0, 255));
                send(a, d);
                prev = d;
            end
        end
        idle(2);
        check_state("rand");
        drain(1, 1, NB);

        // Reset in the middle of the output phase, then a fresh run
        do_reset();
        for (int i = 0; i < 40; i++) send(rand_interior(), int'($urandom_range(90, 110)));
        drain(0, 0, 100);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid", int'(hist_valid), 0);
        chk("abort_bin", int'(hist_bin), 0);
        chk("abort_count", int'(hist_count), 0);
        chk("abort_total", int'(total_count), 0);
        chk("abort_addr_err", int'(addr_err), 0);
        chk("abort_done", int'(done), 0);
        do_reset();
        for (int i = 0; i < 20; i++) send(rand_interior(), int'($urandom_range(0, 7)));
        idle(2);
        check_state("rerun");
        drain(1, 1, NB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
